// File: rtl/mem_access.sv
// Memory-access stage: turns execute load/store requests into single-outstanding req/gnt/rvalid
// bus transactions. Optional `MEM_MISALIGN_CHECK_EN` rejects misaligned accesses without a bus request.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  opfunc3_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_we_o,
  output logic        mem_stall_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic [1:0]  fsm_state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic cnt_clr, cnt_inc;
  logic mem_op, is_store, misalign;
  logic req, complete, timeout, load_ok;
  logic [1:0] off;
  logic [3:0] be_st;
  logic [31:0] wdata_st, load_data;
  logic [7:0] lane8;
  logic [15:0] lane16;

  assign mem_op   = mem_re_i | mem_we_i;
  assign is_store = mem_we_i;
  assign off      = mem_addr_i[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op & (((opfunc3_i[1:0] == 2'b01) & off[0]) |
                              ((opfunc3_i[1:0] == 2'b10) & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_st    = 4'b1111;
    wdata_st = rd_data_i;
    case (opfunc3_i[1:0])
      2'b00: begin
        be_st    = 4'b0001 << off;
        wdata_st = {4{rd_data_i[7:0]}};
      end
      2'b01: begin
        be_st    = 4'b0011 << {off[1], 1'b0};
        wdata_st = {2{rd_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select by shifting the word down; bit 2 of opfunc3 selects zero extension.
  assign lane8  = 8'(dbus_rdata_i >> {off, 3'b000});
  assign lane16 = 16'(dbus_rdata_i >> {off[1], 4'b0000});

  always_comb begin
    load_data = dbus_rdata_i;
    case (opfunc3_i[1:0])
      2'b00:   load_data = {{24{lane8[7] & ~opfunc3_i[2]}}, lane8};
      2'b01:   load_data = {{16{lane16[15] & ~opfunc3_i[2]}}, lane16};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (misalign) begin
            complete = 1'b1;
          end else begin
            req = 1'b1;
            if (dbus_gnt_i) begin
              if (is_store) complete = 1'b1;
              else begin
                state_nxt = S_WAIT;
                cnt_clr   = 1'b1;
              end
            end else begin
              state_nxt = S_REQ;
              cnt_clr   = 1'b1;
            end
          end
        end
      end
      S_REQ: begin
        req = 1'b1;
        // A grant in the expiry cycle still counts as a successful handshake.
        if (dbus_gnt_i) begin
          if (is_store) complete = 1'b1;
          else begin
            state_nxt = S_WAIT;
            cnt_clr   = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          timeout  = 1'b1;
          complete = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (dbus_rvalid_i) complete = 1'b1;
        else if (cnt == CNT_LAST) begin
          timeout  = 1'b1;
          complete = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        if (!stall_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (complete) state_nxt = stall_i ? S_DONE : S_IDLE;
  end

  assign load_ok = complete & ~timeout & ~misalign & ~is_store;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
      rd_we_o    <= 1'b0;
      bus_err_o  <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      bus_err_o  <= timeout;
      misalign_o <= complete & misalign;
      if (complete) begin
        rd_addr_o <= rd_addr_i;
        rd_we_o   <= load_ok & rd_we_i;
        if (load_ok) rd_data_o <= load_data;
      end else if (state == S_IDLE && !mem_op && !stall_i) begin
        rd_addr_o <= rd_addr_i;
        rd_data_o <= rd_data_i;
        rd_we_o   <= rd_we_i;
      end
    end
  end

  // Bus outputs are zero whenever no request is driven, including during reset.
  assign dbus_req_o   = req & rst_ni;
  assign dbus_we_o    = dbus_req_o & is_store;
  assign dbus_addr_o  = dbus_req_o ? {mem_addr_i[31:2], 2'b00} : 32'h0;
  assign dbus_be_o    = dbus_req_o ? (is_store ? be_st : 4'b1111) : 4'b0000;
  assign dbus_wdata_o = dbus_we_o ? wdata_st : 32'h0;
  assign mem_stall_o  = rst_ni & mem_op & (state != S_DONE) & ~complete;
  assign fsm_state_o  = state;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access with a small responsive bus model and a load-result scoreboard.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_stall = 1'b0;
  logic        stall;
  logic [4:0]  rd_addr_in = '0;
  logic [31:0] rd_data_in = '0;
  logic        rd_we_in = 1'b0;
  logic [31:0] mem_addr_in = '0;
  logic        mem_re_in = 1'b0;
  logic        mem_we_in = 1'b0;
  logic [2:0]  opfunc3_in = '0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        rd_we_out, mem_stall, bus_err, misalign;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  assign stall = mem_stall | ext_stall;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .rd_addr_i(rd_addr_in), .rd_data_i(rd_data_in), .rd_we_i(rd_we_in),
    .mem_addr_i(mem_addr_in), .mem_re_i(mem_re_in), .mem_we_i(mem_we_in), .opfunc3_i(opfunc3_in),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr), .dbus_be_o(dbus_be),
    .dbus_wdata_o(dbus_wdata), .dbus_gnt_i(dbus_gnt), .dbus_rvalid_i(dbus_rvalid),
    .dbus_rdata_i(dbus_rdata), .rd_addr_o(rd_addr_out), .rd_data_o(rd_data_out),
    .rd_we_o(rd_we_out), .mem_stall_o(mem_stall), .bus_err_o(bus_err), .misalign_o(misalign),
    .fsm_state_o(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 : (a == 2'd2) ? 4'b0100 : 4'b1000;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Drives one memory op until the cycle in which the stage stops stalling; the bus model
  // grants after gnt_dly request cycles and returns rvalid rv_dly cycles after the grant cycle+1.
  task automatic drive_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd, input int gnt_dly,
                           input int rv_dly, input logic [31:0] rdata,
                           output int stalls, output int grants, output logic [31:0] s_addr,
                           output logic [3:0] s_be, output logic [31:0] s_wdata,
                           output logic s_we, output logic stable, output logic done);
    int rc;
    int gcyc;
    logic seen;
    rd_addr_in = rd; rd_data_in = data; rd_we_in = 1'b1;
    mem_addr_in = addr; opfunc3_in = f3; mem_we_in = st; mem_re_in = ~st;
    stalls = 0; grants = 0; rc = 0; gcyc = -1; seen = 1'b0; stable = 1'b1; done = 1'b0;
    s_addr = '0; s_be = '0; s_wdata = '0; s_we = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      dbus_gnt = 1'b0;
      dbus_rvalid = (gcyc >= 0) && !st && (cyc == gcyc + 1 + rv_dly);
      dbus_rdata = dbus_rvalid ? rdata : $urandom;
      @(negedge clk);
      if (dbus_req) begin
        if (!seen) begin
          s_addr = dbus_addr; s_be = dbus_be; s_wdata = dbus_wdata; s_we = dbus_we; seen = 1'b1;
        end else if (s_addr !== dbus_addr || s_be !== dbus_be || s_wdata !== dbus_wdata) begin
          stable = 1'b0;
        end
        if (rc == gnt_dly) begin
          dbus_gnt = 1'b1; grants++; gcyc = cyc;
        end else begin
          rc++;
        end
      end
      #1;
      if (mem_stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
  endtask

  task automatic clear_ops();
    mem_re_in = 1'b0; mem_we_in = 1'b0; rd_we_in = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, rd_addr_out, rd_data_out, rd_we_out,
         mem_stall, bus_err, misalign, fsm_state} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs req=%b rd_data=%h state=%0d required all 0",
                         dbus_req, rd_data_out, fsm_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    rd_addr_in = 5'd7; rd_data_in = 32'hA5A5_1234; rd_we_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rd_addr_out, rd_data_out, rd_we_out} !== {5'd7, 32'hA5A5_1234, 1'b1}) begin
      errors++; $display("FAIL passthrough: got %0d/%h/%b required 7/a5a51234/1", rd_addr_out, rd_data_out, rd_we_out);
    end
    ext_stall = 1'b1; rd_data_in = 32'h1111_0000; rd_addr_in = 5'd9;
    @(posedge clk); #1;
    checks++;
    if ({rd_addr_out, rd_data_out} !== {5'd7, 32'hA5A5_1234}) begin
      errors++; $display("FAIL passthrough_hold: got %0d/%h required 7/a5a51234", rd_addr_out, rd_data_out);
    end
    ext_stall = 1'b0; clear_ops();
  endtask

  task automatic test_lb();
    int st, gr; logic [31:0] a, w; logic [3:0] be; logic we, stb, dn; logic [31:0] exp;
    exp_q.push_back(32'hFFFF_FF80);
    drive_mem(1'b0, 3'b000, 32'h1003, 32'h0, 5'd5, 0, 0, 32'h8000_0000, st, gr, a, be, w, we, stb, dn);
    exp = exp_q.pop_front();
    checks++;
    if (!dn || st != 1) begin errors++; $display("FAIL lb_stalls: got %0d done=%b required 1", st, dn); end
    checks++;
    if (be !== 4'b1111 || a !== 32'h1000 || we !== 1'b0) begin
      errors++; $display("FAIL lb_request: got be=%b addr=%h we=%b required 1111/00001000/0", be, a, we);
    end
    checks++;
    if ({rd_data_out, rd_we_out, rd_addr_out} !== {exp, 1'b1, 5'd5}) begin
      errors++; $display("FAIL lb_result: got %h/%b/%0d required %h/1/5", rd_data_out, rd_we_out, rd_addr_out, exp);
    end
    clear_ops();
  endtask

  task automatic test_sh_gnt_delay();
    int st, gr; logic [31:0] a, w; logic [3:0] be; logic we, stb, dn;
    drive_mem(1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 5'd3, 3, 0, 32'h0, st, gr, a, be, w, we, stb, dn);
    checks++;
    if (!dn || st != 3 || gr != 1) begin errors++; $display("FAIL sh_stalls: got %0d grants=%0d required 3/1", st, gr); end
    checks++;
    if (be !== 4'b1100 || w !== 32'hBEEF_BEEF || we !== 1'b1 || a !== 32'h2000 || !stb) begin
      errors++; $display("FAIL sh_request: got be=%b wdata=%h we=%b addr=%h stable=%b required 1100/beefbeef/1/2000/1",
                         be, w, we, a, stb);
    end
    checks++;
    if (rd_we_out !== 1'b0) begin errors++; $display("FAIL sh_rd_we: got %b required 0", rd_we_out); end
    clear_ops();
  endtask

  task automatic test_timeout();
    int st, gr; logic [31:0] a, w; logic [3:0] be; logic we, stb, dn;
    drive_mem(1'b0, 3'b010, 32'h100, 32'h0, 5'd4, 0, 1000, 32'h0, st, gr, a, be, w, we, stb, dn);
    checks++;
    if (!dn || st != TO) begin errors++; $display("FAIL timeout_wait_stalls: got %0d done=%b required %0d", st, dn, TO); end
    checks++;
    if (bus_err !== 1'b1 || rd_we_out !== 1'b0) begin
      errors++; $display("FAIL timeout_wait_err: got err=%b rd_we=%b required 1/0", bus_err, rd_we_out);
    end
    clear_ops();
    @(posedge clk); #1;
    checks++;
    if (bus_err !== 1'b0 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL timeout_pulse: got err=%b state=%0d required 0/0", bus_err, fsm_state);
    end
    drive_mem(1'b1, 3'b010, 32'h104, 32'h55, 5'd0, 1000, 0, 32'h0, st, gr, a, be, w, we, stb, dn);
    checks++;
    if (!dn || st != TO || gr != 0 || bus_err !== 1'b1) begin
      errors++; $display("FAIL timeout_req: got stalls=%0d grants=%0d err=%b required %0d/0/1", st, gr, bus_err, TO);
    end
    clear_ops();
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b0) begin errors++; $display("FAIL timeout_req_drop: got req=%b required 0", dbus_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_gnt_wins();
    int st, gr; logic [31:0] a, w; logic [3:0] be; logic we, stb, dn;
    drive_mem(1'b1, 3'b010, 32'h200, 32'h1234_5678, 5'd0, TO, 0, 32'h0, st, gr, a, be, w, we, stb, dn);
    checks++;
    if (!dn || st != TO || gr != 1 || bus_err !== 1'b0) begin
      errors++; $display("FAIL gnt_wins: got stalls=%0d grants=%0d err=%b required %0d/1/0", st, gr, bus_err, TO);
    end
    clear_ops();
  endtask

  task automatic test_done_hold();
    int st, gr, extra; logic [31:0] a, w; logic [3:0] be; logic we, stb, dn; logic [31:0] exp;
    ext_stall = 1'b1;
    exp_q.push_back(32'h1234_5678);
    drive_mem(1'b0, 3'b010, 32'h80, 32'h0, 5'd11, 0, 0, 32'h1234_5678, st, gr, a, be, w, we, stb, dn);
    exp = exp_q.pop_front();
    checks++;
    if (fsm_state !== 2'd3 || rd_data_out !== exp) begin
      errors++; $display("FAIL done_enter: got state=%0d data=%h required 3/%h", fsm_state, rd_data_out, exp);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_0000;
      @(negedge clk);
      if (dbus_req || mem_stall) extra++;
      @(posedge clk); #1;
    end
    dbus_rvalid = 1'b0;
    ext_stall = 1'b0;
    @(negedge clk);
    if (dbus_req) extra++;
    @(posedge clk); #1;
    clear_ops();
    checks++;
    if (gr != 1 || extra != 0 || rd_data_out !== exp || fsm_state !== 2'd0) begin
      errors++; $display("FAIL done_hold: got grants=%0d extra=%0d data=%h state=%0d required 1/0/%h/0",
                         gr, extra, rd_data_out, fsm_state, exp);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    int reqs;
    rd_addr_in = 5'd2; rd_we_in = 1'b1; mem_addr_in = 32'h3001; opfunc3_in = 3'b010; mem_re_in = 1'b1;
    @(negedge clk);
    reqs = dbus_req ? 1 : 0;
    checks++;
    if (reqs != 0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL misalign_noreq: got req=%0d stall=%b required 0/0", reqs, mem_stall);
    end
    @(posedge clk); #1;
    clear_ops();
    checks++;
    if (misalign !== 1'b1 || rd_we_out !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: got mis=%b rd_we=%b required 1/0", misalign, rd_we_out);
    end
    @(posedge clk); #1;
    checks++;
    if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b required 0", misalign); end
`else
    int st, gr; logic [31:0] a, w; logic [3:0] be; logic we, stb, dn;
    exp_q.push_back(32'h89AB_CDEF);
    drive_mem(1'b0, 3'b010, 32'h3001, 32'h0, 5'd2, 0, 0, 32'h89AB_CDEF, st, gr, a, be, w, we, stb, dn);
    checks++;
    if (a !== 32'h3000 || rd_data_out !== exp_q.pop_front() || misalign !== 1'b0) begin
      errors++; $display("FAIL align_down: got addr=%h data=%h mis=%b required 3000/89abcdef/0", a, rd_data_out, misalign);
    end
    clear_ops();
`endif
  endtask

  task automatic test_random();
    int st, gr, gd, rv; logic [31:0] a, w, addr, d, rdata, exp; logic [3:0] be; logic we, stb, dn, is_st;
    logic [2:0] f3;
    logic [2:0] ld_ops[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 10; i++) begin
      is_st = 1'($urandom_range(0, 1));
      f3 = is_st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
      addr = $urandom & 32'hFFFF_FFF0;
      addr[1:0] = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) : (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      d = $urandom; rdata = $urandom; gd = $urandom_range(0, 2); rv = $urandom_range(0, 2);
      if (!is_st) exp_q.push_back(model_load(f3, addr[1:0], rdata));
      drive_mem(is_st, f3, addr, d, 5'(i + 1), gd, rv, rdata, st, gr, a, be, w, we, stb, dn);
      checks++;
      if (!dn || st != (is_st ? gd : 1 + gd + rv) || gr != 1 || !stb) begin
        errors++; $display("FAIL rand_timing[%0d]: got stalls=%0d grants=%0d stable=%b required %0d/1/1",
                           i, st, gr, stb, is_st ? gd : 1 + gd + rv);
      end
      checks++;
      if (is_st) begin
        if (be !== model_be(f3, addr[1:0]) || w !== model_wdata(f3, d) || rd_we_out !== 1'b0) begin
          errors++; $display("FAIL rand_store[%0d]: got be=%b wdata=%h rd_we=%b required %b/%h/0",
                             i, be, w, rd_we_out, model_be(f3, addr[1:0]), model_wdata(f3, d));
        end
      end else begin
        exp = exp_q.pop_front();
        if (rd_data_out !== exp || rd_we_out !== 1'b1 || be !== 4'b1111) begin
          errors++; $display("FAIL rand_load[%0d]: got data=%h rd_we=%b be=%b required %h/1/1111",
                             i, rd_data_out, rd_we_out, be, exp);
        end
      end
      clear_ops();
    end
  endtask

  task automatic test_reset_mid();
    rd_addr_in = 5'd6; rd_data_in = 32'h77; rd_we_in = 1'b1;
    mem_addr_in = 32'h40; opfunc3_in = 3'b010; mem_we_in = 1'b1; dbus_gnt = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fsm_state !== 2'd1 || dbus_req !== 1'b1) begin
      errors++; $display("FAIL reset_mid_setup: got state=%0d req=%b required 1/1", fsm_state, dbus_req);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({dbus_req, dbus_we, dbus_be, rd_addr_out, rd_data_out, rd_we_out, mem_stall, bus_err, misalign, fsm_state} !== '0) begin
      errors++; $display("FAIL reset_mid: got req=%b rd_data=%h rd_we=%b state=%0d required all 0",
                         dbus_req, rd_data_out, rd_we_out, fsm_state);
    end
    clear_ops();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_mid_release: got state=%0d required 0", fsm_state); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh_gnt_delay();
    test_timeout();
    test_gnt_wins();
    test_done_hold();
    test_misalign();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of writeback. It turns execute's registered load/store requests into transactions on a single-outstanding req/gnt/rvalid data bus, handling byte-lane steering, byte enables, load sign/zero extension and bus timeouts. Non-memory results pass straight through. It stalls the pipeline through the pipeline controller while a transaction is in flight.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles a transaction may wait for `dbus_gnt_i` or `dbus_rvalid_i` before it is aborted.
- Data width is `XLEN`, fixed at 32.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: from the pipeline controller; the upstream execute registers are frozen this cycle.
- `rd_addr_i` in 5, `rd_data_i` in `XLEN`, `rd_we_i` in 1: execute result. For stores, `rd_data_i` is the store data (rs2).
- `mem_addr_i` in `XLEN`, `mem_re_i` in 1, `mem_we_i` in 1, `opfunc3_i` in 3: access address, load flag, store flag, size/sign encoding.
- `dbus_req_o` out 1, `dbus_we_o` out 1, `dbus_addr_o` out `XLEN`, `dbus_be_o` out 4, `dbus_wdata_o` out `XLEN`: bus request.
- `dbus_gnt_i` in 1, `dbus_rvalid_i` in 1, `dbus_rdata_i` in `XLEN`: bus grant and read response.
- `rd_addr_o` out 5, `rd_data_o` out `XLEN`, `rd_we_o` out 1: registered, to writeback and forwarding.
- `mem_stall_o` out 1: to the pipeline controller.
- `bus_err_o` out 1: registered one-cycle pulse on timeout.
- `misalign_o` out 1: registered one-cycle pulse; only meaningful with `MEM_MISALIGN_CHECK_EN`.

## Operation
- A memory op is present when `mem_re_i | mem_we_i`. Both flags high at once is treated as a store.
- FSM states:
  - IDLE: a memory op present drives `dbus_req_o` combinationally in the same cycle and enters REQ unless `dbus_gnt_i` is already high.
  - REQ: hold the request until `gnt`. A store completes on `gnt`. A load moves to WAIT on `gnt`.
  - WAIT: `dbus_req_o`=0; the load completes on `rvalid`.
  - DONE: the op has completed but `stall_i` is still high, so it must not be reissued; return to IDLE when `stall_i`=0.
- `rvalid` is counted only from the cycle after `gnt`. `rvalid` in IDLE, REQ or DONE is ignored.
- Request fields: `dbus_addr_o`={`mem_addr_i`[31:2],2'b00}. Request fields stay stable while `dbus_req_o`=1.
- Store data and byte enables, with a = `mem_addr_i`[1:0]:
  - SB (000): `be`=4'b0001<<a, `wdata`=4x byte.
  - SH (001): `be`=4'b0011<<{a[1],1'b0}, `wdata`=2x half.
  - SW (010): `be`=4'b1111.
- Loads use `be`=4'b1111 and pick the lane by `a`:
  - LB (000) sign-extends; LBU (100) zero-extends.
  - LH (001) sign-extends, lane by a[1]; LHU (101) zero-extends.
  - LW (010) takes the full word.
- Completion cycle writes the output registers:
  - load: `rd_data_o`=formatted data, `rd_we_o`=`rd_we_i`.
  - store: `rd_we_o`=0.
- Non-memory op: outputs register the inputs every cycle `stall_i`=0 and hold while `stall_i`=1.
- `mem_stall_o`=1 while a memory op is present, not in DONE, and not completing this cycle.
- Timeout: a counter clears on entry to REQ and on `gnt`, and increments in REQ and WAIT. When it reaches `TIMEOUT_CYCLES`:
  - drop `req`;
  - pulse `bus_err_o`;
  - write `rd_we_o`=0;
  - treat the op as complete (to DONE or IDLE).
- Reset (async, mid-transaction included): FSM=IDLE, counter=0, `dbus_req_o`=0 immediately. All outputs are 0, including `rd_addr_o`, `rd_data_o`, `rd_we_o`, `bus_err_o` and `misalign_o`.

## Timing
- Zero-wait bus (`gnt` same cycle, `rvalid` next): store costs 0 stall cycles; load costs 1 stall cycle, with the result in `rd_data_o` the edge after `rvalid`.
- Each extra `gnt` delay cycle adds 1 stall cycle. Each extra `rvalid` delay cycle adds 1 stall cycle.
- One outstanding transaction at a time; no new `req` until the load's `rvalid` or the timeout.
- `gnt` and timeout expiring in the same cycle: `gnt` wins.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - misaligned cases: LH/LHU/SH with a[0]=1, or LW/SW with a≠0;
  - no bus request is issued;
  - `misalign_o` pulses for one cycle;
  - `rd_we_o`=0;
  - no stall.
- Undefined: `misalign_o` is tied to 0; the low address bits that do not fit the access size are ignored (accesses are aligned down).

## Test plan
- Reset in REQ with `req`=1 → `dbus_req_o`=0 asynchronously; all outputs 0; FSM in IDLE after release.
- LB at 0x1003, zero-wait bus, `rdata`=0x80000000 → `be`=1111, 1 stall cycle, `rd_data_o`=0xFFFFFF80.
- SH at 0x2002, `rd_data_i`=0x0000BEEF, `gnt` after 3 cycles → `be`=1100, `wdata`=0xBEEFBEEF, `mem_stall_o` high 3 cycles, `rd_we_o`=0.
- LW with `gnt` but no `rvalid`, `TIMEOUT_CYCLES`=4 → `bus_err_o` pulse after 4 WAIT cycles, `rd_we_o`=0, stall released.
- Load completes while `stall_i` is held 3 more cycles → exactly one bus request, FSM in DONE, `rd_data_o` stable.
- `MEM_MISALIGN_CHECK_EN`, LW at 0x3001 → no `dbus_req_o`, `misalign_o` one-cycle pulse, `rd_we_o`=0.
